// File: rtl/addsub_multicycle.sv
// Chunk-serial two's-complement adder/subtractor: CHUNK bits per clock, optional
// saturation, carry/overflow/zero/negative flags, valid/ready on input and output.
module addsub_multicycle #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("addsub_multicycle: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic [1:0]       op_reg;

    logic [CHUNK:0]   slice_sum;
    logic [WIDTH-1:0] acc_next;
    logic             b_orig_msb;
    logic             ovf_next;
    logic [WIDTH-1:0] res_next;
    logic             last;

    // Handshake: an operation transfers on a rising edge with in_valid && in_ready;
    // a result transfers on a rising edge with out_valid && out_ready. in_ready is
    // high only in IDLE, so no accept can coincide with the DONE->IDLE edge.
    assign in_ready = (state == IDLE);
    assign last     = (idx == IW'(NCH - 1));

    always_comb begin
        slice_sum = {1'b0, a_reg[idx*CHUNK +: CHUNK]}
                  + {1'b0, b_reg[idx*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry};
        acc_next = acc;
        acc_next[idx*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
        // b_reg holds the inverted operand for subtraction; undo it for the overflow rule.
        b_orig_msb = b_reg[WIDTH-1] ^ op_reg[0];
        if (op_reg[0]) begin
            ovf_next = (a_reg[WIDTH-1] != b_orig_msb) && (acc_next[WIDTH-1] != a_reg[WIDTH-1]);
        end else begin
            ovf_next = (a_reg[WIDTH-1] == b_orig_msb) && (acc_next[WIDTH-1] != a_reg[WIDTH-1]);
        end
        res_next = acc_next;
        if (op_reg[1] && ovf_next) begin
            res_next = a_reg[WIDTH-1] ? MOST_NEG : MOST_POS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            op_reg    <= 2'b00;
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg  <= a;
                        b_reg  <= b ^ {WIDTH{op[0]}};
                        op_reg <= op;
                        carry  <= op[0];
                        idx    <= '0;
                        acc    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    carry <= slice_sum[CHUNK];
                    idx   <= idx + 1'b1;
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= res_next;
                        carry_out <= slice_sum[CHUNK];
                        overflow  <= ovf_next;
                        zero      <= (res_next == '0);
                        negative  <= res_next[WIDTH-1];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_multicycle.sv
// Bench driving three instances (CHUNK = 8, 1, 32) with shared stimulus and a
// table of hand-computed vectors, plus backpressure and mid-operation reset.
module tb_addsub_multicycle;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0]  op = 2'b00;
    logic        out_ready = 1'b1;

    logic [31:0] res [3];
    logic        ir [3];
    logic        ov [3];
    logic        co [3];
    logic        vf [3];
    logic        zr [3];
    logic        ng [3];

    int checks = 0;
    int errors = 0;
    int exp_lat [3] = '{4, 32, 1};

    int          cap_lat [3];
    logic [31:0] cap_res [3];
    logic [3:0]  cap_flags [3];

    always #5 clk = ~clk;

    addsub_multicycle #(.WIDTH(32), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b), .op(op),
        .out_valid(ov[0]), .out_ready(out_ready), .result(res[0]), .carry_out(co[0]),
        .overflow(vf[0]), .zero(zr[0]), .negative(ng[0]));
    addsub_multicycle #(.WIDTH(32), .CHUNK(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b), .op(op),
        .out_valid(ov[1]), .out_ready(out_ready), .result(res[1]), .carry_out(co[1]),
        .overflow(vf[1]), .zero(zr[1]), .negative(ng[1]));
    addsub_multicycle #(.WIDTH(32), .CHUNK(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b), .op(op),
        .out_valid(ov[2]), .out_ready(out_ready), .result(res[2]), .carry_out(co[2]),
        .overflow(vf[2]), .zero(zr[2]), .negative(ng[2]));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] result;
        logic [3:0]  flags;  // {carry_out, overflow, zero, negative}
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Presents one operation for a single accept edge, then scrambles the inputs.
    task automatic start_op(input logic [31:0] va, input logic [31:0] vb, input logic [1:0] vop);
        a = va;
        b = vb;
        op = vop;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        op = 2'($urandom_range(0, 3));
    endtask

    // Records, per instance, the first edge at which out_valid is seen and the outputs then.
    task automatic wait_done();
        bit seen [3];
        for (int d = 0; d < 3; d++) begin
            seen[d] = 1'b0;
            cap_lat[d] = -1;
        end
        for (int e = 1; e <= 40 && !(seen[0] && seen[1] && seen[2]); e++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                if (!seen[d] && ov[d]) begin
                    seen[d] = 1'b1;
                    cap_lat[d] = e;
                    cap_res[d] = res[d];
                    cap_flags[d] = {co[d], vf[d], zr[d], ng[d]};
                end
            end
        end
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 5 && !(ir[0] && ir[1] && ir[2]); k++) begin
            @(posedge clk);
            #1;
        end
        check({name, " idle"}, {29'd0, ir[0], ir[1], ir[2]}, 32'd7);
    endtask

    task automatic check_caps(input string tag, input logic [31:0] er, input logic [3:0] ef);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s d%0d latency", tag, d), 32'(cap_lat[d]), 32'(exp_lat[d]));
            check($sformatf("%s d%0d result", tag, d), cap_res[d], er);
            check($sformatf("%s d%0d carry", tag, d), {31'd0, cap_flags[d][3]}, {31'd0, ef[3]});
            check($sformatf("%s d%0d overflow", tag, d), {31'd0, cap_flags[d][2]}, {31'd0, ef[2]});
            check($sformatf("%s d%0d zero", tag, d), {31'd0, cap_flags[d][1]}, {31'd0, ef[1]});
            check($sformatf("%s d%0d negative", tag, d), {31'd0, cap_flags[d][0]}, {31'd0, ef[0]});
        end
    endtask

    initial begin
        logic [31:0] held_res;
        logic [3:0]  held_flags;

        vecs[0]  = '{32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 32'h8000_0000, 4'b0101};
        vecs[1]  = '{32'h7FFF_FFFF, 32'h0000_0001, 2'b10, 32'h7FFF_FFFF, 4'b0100};
        vecs[2]  = '{32'h8000_0000, 32'h0000_0001, 2'b11, 32'h8000_0000, 4'b1101};
        vecs[3]  = '{32'h8000_0000, 32'h0000_0001, 2'b01, 32'h7FFF_FFFF, 4'b1100};
        vecs[4]  = '{32'h1234_5678, 32'h1234_5678, 2'b01, 32'h0000_0000, 4'b1010};
        vecs[5]  = '{32'h0000_0000, 32'h0000_0001, 2'b01, 32'hFFFF_FFFF, 4'b0001};
        vecs[6]  = '{32'h00FF_FFFF, 32'h0000_0001, 2'b00, 32'h0100_0000, 4'b0000};
        vecs[7]  = '{32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 32'h0000_0000, 4'b1010};
        vecs[8]  = '{32'h8000_0000, 32'h8000_0000, 2'b10, 32'h8000_0000, 4'b1101};
        vecs[9]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'h7FFF_FFFF, 4'b0100};
        vecs[10] = '{32'h0000_0005, 32'h0000_0003, 2'b10, 32'h0000_0008, 4'b0000};
        vecs[11] = '{32'h0000_0005, 32'h0000_0003, 2'b01, 32'h0000_0002, 4'b1000};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset d%0d result", d), res[d], 32'd0);
            check($sformatf("reset d%0d flags", d), {27'd0, co[d], vf[d], zr[d], ng[d], ov[d]}, 32'd0);
            check($sformatf("reset d%0d in_ready", d), {31'd0, ir[d]}, 32'd1);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].op);
            wait_done();
            check_caps($sformatf("vec%0d", i), vecs[i].result, vecs[i].flags);
            wait_idle($sformatf("vec%0d", i));
        end

        // Backpressure: results held, no accept while DONE, release returns to IDLE.
        out_ready = 1'b0;
        start_op(32'h1234_5678, 32'h0000_0001, 2'b00);
        wait_done();
        check_caps("bp", 32'h1234_5679, 4'b0000);
        held_res = res[0];
        held_flags = {co[0], vf[0], zr[0], ng[0]};
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin
                a = 32'h0000_0001;
                b = 32'h0000_0001;
                op = 2'b00;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            check($sformatf("bp c%0d result", c), res[0], held_res);
            check($sformatf("bp c%0d flags", c), {28'd0, co[0], vf[0], zr[0], ng[0]}, {28'd0, held_flags});
            check($sformatf("bp c%0d valid_ready", c), {30'd0, ov[0], ir[0]}, 32'd2);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("bp release d%0d valid_ready", d), {30'd0, ov[d], ir[d]}, 32'd1);
            check($sformatf("bp release d%0d result", d), res[d], 32'h1234_5679);
        end

        // Reset two edges after accept.
        start_op(32'h00FF_FFFF, 32'h0000_0001, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("midrst d%0d result", d), res[d], 32'd0);
            check($sformatf("midrst d%0d flags", d), {27'd0, co[d], vf[d], zr[d], ng[d], ov[d]}, 32'd0);
            check($sformatf("midrst d%0d in_ready", d), {31'd0, ir[d]}, 32'd1);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        start_op(32'h8000_0000, 32'h0000_0001, 2'b11);
        wait_done();
        check_caps("postrst", 32'h8000_0000, 4'b1101);
        wait_idle("postrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/addsub_multicycle.md
Name: addsub_multicycle

Overview:
Parametrised, chunk-serial two's-complement adder/subtractor for the ALU datapath. It processes CHUNK bits per clock, so one operation takes WIDTH/CHUNK cycles, trading latency for a shorter carry path. It adds saturating add/sub modes, full flags (carry, overflow, zero, negative) and a valid/ready handshake on both input and output.

Parameters:
WIDTH, 32, operand/result width in bits
CHUNK, 8, bits added per cycle; WIDTH % CHUNK != 0 is an elaboration error; CHUNK == WIDTH is legal (single-cycle compute)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand/op presented
in_ready  output  1  block can accept an operation
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  2  00 add, 01 sub, 10 saturating add, 11 saturating sub
out_valid  output  1  result and flags valid
out_ready  input  1  consumer takes result
result  output  WIDTH  sum/difference, post-saturation
carry_out  output  1  final carry; for sub, 1 = no borrow
overflow  output  1  raw signed overflow, before saturation
zero  output  1  result == 0
negative  output  1  result[WIDTH-1]

Behaviour:
- NCH = WIDTH/CHUNK. States are IDLE, CALC, DONE.
- Reset (async, any state, including mid-CALC):
  - State goes to IDLE; chunk index, carry and accumulator clear.
  - result, carry_out, overflow, zero and negative all go to 0; out_valid goes to 0.
  - Any in-flight operation is discarded.
- in_ready = (state == IDLE). No operation is accepted while rst is high.
- IDLE:
  - Accept on a rising edge with in_valid && in_ready.
  - Latch a, b XOR {WIDTH{op[0]}}, and op. Carry register = op[0]. Index = 0. Go to CALC.
- CALC:
  - Each edge adds slice [idx*CHUNK +: CHUNK] of A, modified B and the carry register.
  - The sum slice is written to the accumulator; the chunk carry-out goes to the carry register; idx increments.
  - On the edge processing idx == NCH-1, go to DONE and register the outputs.
- Output registering on entry to DONE:
  - overflow: for add, a[MSB]==b[MSB] && sum[MSB]!=a[MSB]. For sub, a[MSB]!=b[MSB] && diff[MSB]!=a[MSB]. Original b is used, not the inverted copy.
  - Saturation: if op[1] && overflow, result = a[MSB] ? {1,0...0} (most negative) : {0,1...1} (most positive). Otherwise result = accumulator.
  - carry_out = final carry and is never altered by saturation.
  - zero and negative are computed from the final (post-saturation) result.
- Latency: out_valid rises exactly NCH rising edges after the accept edge.
- DONE:
  - out_valid = 1. Outputs are held stable while out_ready = 0, for any duration.
  - in_valid is ignored.
  - On an edge with out_ready = 1, go to IDLE and out_valid drops. result and flags keep their values until the next DONE entry.
- There is no accept in the same cycle as the DONE to IDLE transition. Minimum spacing between accepts is NCH+2 edges when out_ready is held at 1.
- a, b and op may change freely after the accept edge without affecting the operation.
- In CALC and IDLE, out_valid = 0 and the outputs show the previous result.

Test Plan:
- Add overflow, op=00, a=0x7FFFFFFF, b=0x00000001, defaults -> out_valid exactly 4 edges after accept; result=0x80000000, overflow=1, carry_out=0, negative=1, zero=0.
- Saturating add, op=10, same operands -> result=0x7FFFFFFF, overflow=1, negative=0. Saturating sub, op=11, a=0x80000000, b=1 -> result=0x80000000, overflow=1. Same with op=01 -> 0x7FFFFFFF.
- Sub to zero, op=01, a=b=0x12345678 -> result=0, zero=1, carry_out=1, overflow=0. Then a=0, b=1 -> result=0xFFFFFFFF, carry_out=0, negative=1.
- Cross-chunk carry: a=0x00FFFFFF, b=1, op=00 -> result=0x01000000. Re-run with CHUNK=1 -> latency 32 edges. Re-run with CHUNK=32 -> latency 1 edge, same result.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result and flags stable, in_ready=0, and a pulsed in_valid is not accepted. out_ready=1 -> IDLE next edge, in_ready=1.
- Reset mid-CALC: assert rst 2 edges after accept -> out_valid=0, all outputs 0, in_ready=1 immediately. A new op after rst deasserts completes correctly.
